// File: rtl/subleq_pkg.sv
// Shared types, default widths and the next-PC rule for the SUBLEQ core.
package subleq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        RD_C  = 3'd3,
        RD_MA = 3'd4,
        RD_MB = 3'd5,
        WR_B  = 3'd6,
        HALT  = 3'd7
    } state_t;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_CNT_W  = 32;

    // Wide enough for any address width in use; callers truncate to ADDR_W,
    // which also gives the modulo-2^ADDR_W wrap of pc + 3.
    localparam int PC_CALC_W = 64;

    function automatic logic [PC_CALC_W-1:0] next_pc(
        input logic [PC_CALC_W-1:0] pc,
        input logic [PC_CALC_W-1:0] c,
        input logic                 leq
    );
        return leq ? c : pc + PC_CALC_W'(3);
    endfunction

endpackage

// File: rtl/subleq_mem_if.sv
// Single-outstanding memory request sequencer: registers a request on issue,
// holds it stable until acked, and flags completion in the ack cycle.
module subleq_mem_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              req_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    // An issue in the ack cycle chains straight into the next access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (issue) begin
            req_reg   <= 1'b1;
            we_reg    <= issue_we;
            addr_reg  <= issue_addr;
            wdata_reg <= issue_wdata;
        end else if (done) begin
            req_reg <= 1'b0;
            we_reg  <= 1'b0;
        end
    end

    assign done      = req_reg & mem_ack;
    assign rdata     = mem_rdata;
    assign mem_req   = req_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: rtl/subleq_core_p.sv
// Multi-cycle SUBLEQ core: fetches A/B/C, reads mem[A] and mem[B], writes
// mem[B]-mem[A] back and branches to C when the result is <= 0.
module subleq_core_p
    import subleq_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [CNT_W-1:0]  retired_reg, retired_next;
    logic              halted_reg, halted_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [DATA_W-1:0] c_reg, c_next;
    logic [DATA_W-1:0] ma_reg, ma_next;
    logic [DATA_W-1:0] mb_reg, mb_next;

    logic              issue;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata;
    logic              done;
    logic [DATA_W-1:0] rdata;

    logic [DATA_W-1:0] result;
    logic              leq;
    logic [ADDR_W-1:0] pc_upd;

    subleq_mem_if #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem_if (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .issue_we   (issue_we),
        .issue_addr (issue_addr),
        .issue_wdata(issue_wdata),
        .done       (done),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    assign result = mb_reg - ma_reg;
    assign leq    = result[DATA_W-1] | (result == '0);
    assign pc_upd = ADDR_W'(next_pc(PC_CALC_W'(pc_reg), PC_CALC_W'(c_reg), leq));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pc_reg      <= ADDR_W'(RESET_PC);
            retired_reg <= '0;
            halted_reg  <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            ma_reg      <= '0;
            mb_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            retired_reg <= retired_next;
            halted_reg  <= halted_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            c_reg       <= c_next;
            ma_reg      <= ma_next;
            mb_reg      <= mb_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        retired_next = retired_reg;
        halted_next  = halted_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        c_next       = c_reg;
        ma_next      = ma_reg;
        mb_next      = mb_reg;
        issue        = 1'b0;
        issue_we     = 1'b0;
        issue_addr   = pc_reg;
        issue_wdata  = '0;
        case (state_reg)
            IDLE: begin
                if (run) begin
                    state_next = RD_A;
                    issue      = 1'b1;
                    issue_addr = pc_reg;
                end
            end
            RD_A: begin
                if (done) begin
                    a_next     = rdata;
                    state_next = RD_B;
                    issue      = 1'b1;
                    issue_addr = pc_reg + ADDR_W'(1);
                end
            end
            RD_B: begin
                if (done) begin
                    b_next     = rdata;
                    state_next = RD_C;
                    issue      = 1'b1;
                    issue_addr = pc_reg + ADDR_W'(2);
                end
            end
            RD_C: begin
                if (done) begin
                    c_next     = rdata;
                    state_next = RD_MA;
                    issue      = 1'b1;
                    issue_addr = ADDR_W'(a_reg);
                end
            end
            RD_MA: begin
                if (done) begin
                    ma_next    = rdata;
                    state_next = RD_MB;
                    issue      = 1'b1;
                    issue_addr = ADDR_W'(b_reg);
                end
            end
            RD_MB: begin
                // Write data is formed from the live read so WR_B can issue back-to-back.
                if (done) begin
                    mb_next     = rdata;
                    state_next  = WR_B;
                    issue       = 1'b1;
                    issue_we    = 1'b1;
                    issue_addr  = ADDR_W'(b_reg);
                    issue_wdata = rdata - ma_reg;
                end
            end
            WR_B: begin
                if (done) begin
                    retired_next = retired_reg + CNT_W'(1);
                    if (leq && c_reg[DATA_W-1]) begin
                        halted_next = 1'b1;
                        state_next  = HALT;
                    end else begin
                        pc_next = pc_upd;
                        if (run) begin
                            state_next = RD_A;
                            issue      = 1'b1;
                            issue_addr = pc_upd;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE) && (state_reg != HALT);
    assign halted  = halted_reg;
    assign pc      = pc_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_subleq_core_p.sv
// Directed bench for subleq_core_p with an ISA-level model predicting every
// memory access, plus a narrow-width instance for address/data wraparound.
module tb_subleq_core_p;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        run;
    logic        busy, halted;
    logic [15:0] pc;
    logic [31:0] retired;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    logic        s_run;
    logic        s_busy, s_halted;
    logic [3:0]  s_pc;
    logic [7:0]  s_retired;
    logic        s_mem_req, s_mem_we, s_mem_ack;
    logic [3:0]  s_mem_addr;
    logic [7:0]  s_mem_wdata, s_mem_rdata;

    logic [63:0] mem  [0:255];
    logic [63:0] mmem [0:255];
    logic [7:0]  smem [0:15];
    int unsigned lat_cnt;
    int unsigned lat_max;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [63:0] data;
        logic [15:0] ipc;
        logic [31:0] iret;
    } txn_t;

    txn_t        expq[$];
    logic [3:0]  s_addrs[$];
    int          n_vec, n_err;
    logic [15:0] model_pc;
    int          model_ret;
    bit          model_halt;

    bit          pend;
    logic        h_we;
    logic [15:0] h_addr;
    logic [63:0] h_wdata;
    txn_t        cur;

    assign mem_ack     = mem_req && (lat_cnt == 0);
    assign mem_rdata   = mem[mem_addr[7:0]];
    assign s_mem_ack   = s_mem_req;
    assign s_mem_rdata = smem[s_mem_addr];

    subleq_core_p #(
        .DATA_W(64), .ADDR_W(16), .RESET_PC(0), .CNT_W(32)
    ) u_dut (
        .clk(clk), .rst(rst), .run(run), .busy(busy), .halted(halted),
        .pc(pc), .retired(retired), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    subleq_core_p #(
        .DATA_W(8), .ADDR_W(4), .RESET_PC(14), .CNT_W(8)
    ) u_small (
        .clk(clk), .rst(rst), .run(s_run), .busy(s_busy), .halted(s_halted),
        .pc(s_pc), .retired(s_retired), .mem_req(s_mem_req), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_ack(s_mem_ack),
        .mem_rdata(s_mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 64'd0;
            mmem[i] = 64'd0;
        end
        for (int i = 0; i < 16; i++) smem[i] = 8'd0;
    endtask

    task automatic put(input int a, input logic [63:0] v);
        mem[a]  = v;
        mmem[a] = v;
    endtask

    // ISA interpreter: queues the exact access sequence each instruction implies.
    task automatic model_run(input int max_i, input logic [15:0] start_pc);
        logic [15:0] p;
        logic [63:0] a, b, c, r;
        int          n;
        p = start_pc;
        n = 0;
        model_halt = 0;
        while (n < max_i && !model_halt) begin
            a = mmem[8'(p)];
            b = mmem[8'(p + 16'd1)];
            c = mmem[8'(p + 16'd2)];
            expq.push_back('{we: 1'b0, addr: p,           data: 64'd0, ipc: p, iret: 32'(n)});
            expq.push_back('{we: 1'b0, addr: p + 16'd1,   data: 64'd0, ipc: p, iret: 32'(n)});
            expq.push_back('{we: 1'b0, addr: p + 16'd2,   data: 64'd0, ipc: p, iret: 32'(n)});
            expq.push_back('{we: 1'b0, addr: a[15:0],     data: 64'd0, ipc: p, iret: 32'(n)});
            expq.push_back('{we: 1'b0, addr: b[15:0],     data: 64'd0, ipc: p, iret: 32'(n)});
            r = mmem[b[7:0]] - mmem[a[7:0]];
            expq.push_back('{we: 1'b1, addr: b[15:0],     data: r,     ipc: p, iret: 32'(n)});
            mmem[b[7:0]] = r;
            n++;
            if ($signed(r) <= 0) begin
                if ($signed(c) < 0) model_halt = 1;
                else p = c[15:0];
            end else begin
                p = p + 16'd3;
            end
        end
        model_pc  = p;
        model_ret = n;
    endtask

    task automatic enter_reset();
        rst   = 1'b1;
        run   = 1'b0;
        s_run = 1'b0;
        repeat (2) @(negedge clk);
        expq.delete();
        s_addrs.delete();
        clear_mem();
    endtask

    task automatic wait_idle(input int lim, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_halt(input int lim);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (halted) ok = 1;
        end
        chk("halt_in_time", 64'(ok), 64'd1);
    endtask

    task automatic wait_access(input int lim, input logic [15:0] addr, input logic [31:0] ret, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == addr && retired == ret) ok = 1;
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic load_single();
        put(0, 64'd10); put(1, 64'd11); put(2, 64'd6);
        put(10, 64'd3); put(11, 64'd5);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        lat_cnt = 0;
        lat_max = 0;
        pend    = 0;
        rst     = 1'b1;
        run     = 1'b0;
        s_run   = 1'b0;
        clear_mem();

        fork
            forever begin
                @(posedge clk);
                if (mem_req && mem_ack) begin
                    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
                    lat_cnt <= $urandom_range(lat_max, 0);
                end else if (mem_req) begin
                    lat_cnt <= lat_cnt - 1;
                end else begin
                    lat_cnt <= $urandom_range(lat_max, 0);
                end
            end
            forever begin
                @(posedge clk);
                if (s_mem_req) begin
                    if (s_mem_we) smem[s_mem_addr] <= s_mem_wdata;
                    else s_addrs.push_back(s_mem_addr);
                end
            end
            forever begin
                @(negedge clk);
                if (rst || !mem_req) begin
                    pend = 0;
                end else begin
                    if (pend) begin
                        chk("hold_addr", 64'(mem_addr), 64'(h_addr));
                        chk("hold_we", 64'(mem_we), 64'(h_we));
                        chk("hold_wdata", mem_wdata, h_wdata);
                    end
                    if (mem_ack) begin
                        if (expq.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_access: got addr 0x%0h we %0b, required none", mem_addr, mem_we);
                        end else begin
                            cur = expq.pop_front();
                            chk("txn_we", 64'(mem_we), 64'(cur.we));
                            chk("txn_addr", 64'(mem_addr), 64'(cur.addr));
                            chk("txn_pc", 64'(pc), 64'(cur.ipc));
                            chk("txn_retired", 64'(retired), 64'(cur.iret));
                            if (cur.we) chk("txn_wdata", mem_wdata, cur.data);
                        end
                        pend = 0;
                    end else begin
                        pend    = 1;
                        h_addr  = mem_addr;
                        h_we    = mem_we;
                        h_wdata = mem_wdata;
                    end
                end
            end
        join_none

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_small_pc", 64'(s_pc), 64'd14);

        // Single instruction, combinational ack: six access cycles.
        enter_reset();
        lat_max = 0;
        load_single();
        model_run(1, 16'd0);
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        chk("t1_req_cycle1", 64'(mem_req), 64'd1);
        run = 1'b0;
        repeat (5) @(negedge clk);
        chk("t1_pc_in_wr", 64'(pc), 64'd0);
        chk("t1_we_in_wr", 64'(mem_we), 64'd1);
        @(negedge clk);
        chk("t1_pc", 64'(pc), 64'd3);
        chk("t1_retired", 64'(retired), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_req_idle", 64'(mem_req), 64'd0);
        chk("t1_mem11", mem[11], 64'd2);
        chk("t1_model_pc", 64'(pc), 64'(model_pc));
        chk("t1_drained", 64'(expq.size()), 64'd0);

        // Branch taken onto a negative C halts.
        enter_reset();
        lat_max = 0;
        put(0, 64'd10); put(1, 64'd10); put(2, 64'hFFFF_FFFF_FFFF_FFFF);
        put(10, 64'd7);
        model_run(10, 16'd0);
        rst = 1'b0;
        run = 1'b1;
        wait_halt(50);
        chk("t2_mem10", mem[10], 64'd0);
        chk("t2_pc", 64'(pc), 64'd0);
        chk("t2_busy", 64'(busy), 64'd0);
        chk("t2_retired", 64'(retired), 64'd1);
        chk("t2_model_halt", 64'(halted), 64'(model_halt));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t2_req_in_halt", 64'(mem_req), 64'd0);
        end
        chk("t2_halted_sticky", 64'(halted), 64'd1);
        chk("t2_drained", 64'(expq.size()), 64'd0);

        // Variable latency, run dropped while reading mem[A].
        enter_reset();
        lat_max = 4;
        load_single();
        model_run(1, 16'd0);
        rst = 1'b0;
        run = 1'b1;
        wait_access(100, 16'd10, 32'd0, "t3_reach_rd_ma");
        run = 1'b0;
        wait_idle(200, "t3_idle_in_time");
        chk("t3_mem11", mem[11], 64'd2);
        chk("t3_pc", 64'(pc), 64'd3);
        chk("t3_retired", 64'(retired), 64'd1);
        chk("t3_drained", 64'(expq.size()), 64'd0);

        // Countdown loop: five loop instructions, then a halting one.
        enter_reset();
        lat_max = 4;
        put(0, 64'd20); put(1, 64'd21); put(2, 64'd6);
        put(3, 64'd22); put(4, 64'd22); put(5, 64'd0);
        put(6, 64'd22); put(7, 64'd22); put(8, 64'hFFFF_FFFF_FFFF_FFFF);
        put(20, 64'd1); put(21, 64'd3);
        model_run(50, 16'd0);
        rst = 1'b0;
        run = 1'b1;
        wait_halt(2000);
        chk("t4_retired", 64'(retired), 64'd6);
        chk("t4_pc", 64'(pc), 64'd6);
        chk("t4_mem21", mem[21], 64'd0);
        chk("t4_model_ret", 64'(retired), 64'(model_ret));
        chk("t4_model_pc", 64'(pc), 64'(model_pc));
        chk("t4_drained", 64'(expq.size()), 64'd0);

        // Narrow instance: fetch wraps 14,15,0; 0x80-1 = 0x7F stays positive.
        enter_reset();
        smem[14] = 8'd5; smem[15] = 8'd6; smem[0] = 8'd9;
        smem[5]  = 8'd1; smem[6]  = 8'h80;
        rst   = 1'b0;
        s_run = 1'b1;
        @(negedge clk);
        s_run = 1'b0;
        repeat (8) @(negedge clk);
        chk("w_reads", 64'(s_addrs.size()), 64'd5);
        chk("w_fetch0", 64'(s_addrs[0]), 64'd14);
        chk("w_fetch1", 64'(s_addrs[1]), 64'd15);
        chk("w_fetch2", 64'(s_addrs[2]), 64'd0);
        chk("w_result", 64'(smem[6]), 64'h7F);
        chk("w_pc", 64'(s_pc), 64'd1);
        chk("w_retired", 64'(s_retired), 64'd1);
        chk("w_halted", 64'(s_halted), 64'd0);
        chk("w_busy", 64'(s_busy), 64'd0);

        // Asynchronous reset while a request is outstanding.
        enter_reset();
        lat_max = 0;
        load_single();
        model_run(2, 16'd0);
        rst = 1'b0;
        run = 1'b1;
        wait_access(50, 16'd4, 32'd1, "t5_reach_second");
        chk("t5_pc_before", 64'(pc), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_req_async", 64'(mem_req), 64'd0);
        chk("t5_pc_async", 64'(pc), 64'd0);
        chk("t5_retired_async", 64'(retired), 64'd0);
        chk("t5_busy_async", 64'(busy), 64'd0);
        expq.delete();
        run = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
